// File: rtl/merge_drain_ctrl.sv
// Drives a two-input merge atom from two sorted source lanes. When a lane runs out it feeds a sentinel,
// then flushes the atom once the atom emits a sentinel, and reports the number of valid entries merged.
`ifndef DATA_WIDTH_ADD_STG
`define DATA_WIDTH_ADD_STG 32
`endif
`ifndef BITS_ROW_IDX
`define BITS_ROW_IDX 8
`endif

module merge_drain_ctrl #(
    parameter int DATA_WIDTH = `DATA_WIDTH_ADD_STG,
    parameter int BITS_CNT   = 16
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  lane0_empty,
    input  logic                  lane1_empty,
    input  logic                  src0_valid,
    input  logic                  src1_valid,
    input  logic                  src0_last,
    input  logic                  src1_last,
    input  logic [DATA_WIDTH-1:0] src0_data,
    input  logic [DATA_WIDTH-1:0] src1_data,
    output logic                  src0_ready,
    output logic                  src1_ready,
    output logic                  f0_wr_en,
    output logic                  f1_wr_en,
    output logic [DATA_WIDTH-1:0] din_f0,
    output logic [DATA_WIDTH-1:0] din_f1,
    input  logic                  f0_full,
    input  logic                  f1_full,
    input  logic                  atom_wr_en,
    input  logic [DATA_WIDTH-1:0] atom_dout,
    output logic                  global_en,
    output logic                  atom_rst_b,
    output logic                  busy,
    output logic                  done,
    output logic                  err_order,
    output logic [BITS_CNT-1:0]   out_count
);
    // state | meaning
    // IDLE  | waiting for start
    // RUN   | atom enabled, lanes forwarded, sentinels injected as lanes end
    // FLUSH | atom held in reset for one cycle to drop the residual sentinel
    // DONE  | one-cycle completion pulse
    localparam int ROW_W = `BITS_ROW_IDX;
    localparam logic [DATA_WIDTH-1:0] SENTINEL = {{ROW_W{1'b1}}, {(DATA_WIDTH-ROW_W){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t              state, state_nxt;
    logic [1:0]          ended;
    logic [1:0]          sentinel_sent;
    logic [ROW_W-1:0]    prev_row0, prev_row1;
    logic [BITS_CNT-1:0] cnt;
    logic                err;
    logic                acc0, acc1, inj0, inj1;
    logic                atom_dout_unused;

    assign atom_dout_unused = ^atom_dout[DATA_WIDTH-1:1];

    always_comb begin
        state_nxt  = state;
        src0_ready = 1'b0;
        src1_ready = 1'b0;
        acc0       = 1'b0;
        acc1       = 1'b0;
        inj0       = 1'b0;
        inj1       = 1'b0;
        f0_wr_en   = 1'b0;
        f1_wr_en   = 1'b0;
        din_f0     = '0;
        din_f1     = '0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                // abort wins over a sentinel emitted in the same cycle
                if (abort || (atom_wr_en && !atom_dout[0])) state_nxt = FLUSH;
                src0_ready = !ended[0] && !f0_full;
                src1_ready = !ended[1] && !f1_full;
                acc0       = src0_valid && src0_ready;
                acc1       = src1_valid && src1_ready;
                inj0       = ended[0] && !sentinel_sent[0] && !f0_full;
                inj1       = ended[1] && !sentinel_sent[1] && !f1_full;
                f0_wr_en   = acc0 || inj0;
                f1_wr_en   = acc1 || inj1;
                din_f0     = acc0 ? src0_data : (inj0 ? SENTINEL : '0);
                din_f1     = acc1 ? src1_data : (inj1 ? SENTINEL : '0);
            end
            FLUSH: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state         <= IDLE;
            ended         <= '0;
            sentinel_sent <= '0;
            prev_row0     <= '0;
            prev_row1     <= '0;
            cnt           <= '0;
            err           <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                ended         <= {lane1_empty, lane0_empty};
                sentinel_sent <= '0;
                prev_row0     <= '0;
                prev_row1     <= '0;
                cnt           <= '0;
                err           <= 1'b0;
            end else if (state == RUN) begin
                // prev rows start at zero, so the first beat of a lane can never look out of order
                if (acc0) begin
                    prev_row0 <= src0_data[DATA_WIDTH-1 -: ROW_W];
                    if (src0_data[DATA_WIDTH-1 -: ROW_W] < prev_row0) err <= 1'b1;
                    if (src0_last) ended[0] <= 1'b1;
                end
                if (acc1) begin
                    prev_row1 <= src1_data[DATA_WIDTH-1 -: ROW_W];
                    if (src1_data[DATA_WIDTH-1 -: ROW_W] < prev_row1) err <= 1'b1;
                    if (src1_last) ended[1] <= 1'b1;
                end
                if (inj0) sentinel_sent[0] <= 1'b1;
                if (inj1) sentinel_sent[1] <= 1'b1;
                if (atom_wr_en && atom_dout[0]) cnt <= cnt + 1'b1;
            end
        end
    end

    assign global_en  = (state == RUN);
    assign busy       = (state == RUN) || (state == FLUSH);
    assign done       = (state == DONE);
    assign atom_rst_b = rst_b && (state != FLUSH);
    assign out_count  = cnt;
    assign err_order  = err;

endmodule

// File: tb/tb_merge_drain_ctrl.sv
// Bench for merge_drain_ctrl: a behavioural merge atom with small input FIFOs closes the loop, and each
// job is checked against the sorted union of the lane rows, per-lane FIFO write logs and pulse counts.
module tb_merge_drain_ctrl;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam logic [DW-1:0] SENT = {8'hFF, 24'h0};

    logic          clk, rst_b, start, abort, lane0_empty, lane1_empty;
    logic          src0_valid, src1_valid, src0_last, src1_last;
    logic [DW-1:0] src0_data, src1_data;
    logic          src0_ready, src1_ready, f0_wr_en, f1_wr_en;
    logic [DW-1:0] din_f0, din_f1;
    logic          f0_full, f1_full, atom_wr_en;
    logic [DW-1:0] atom_dout;
    logic          global_en, atom_rst_b, busy, done, err_order;
    logic [CW-1:0] out_count;

    merge_drain_ctrl #(.DATA_WIDTH(DW), .BITS_CNT(CW)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
        .lane0_empty(lane0_empty), .lane1_empty(lane1_empty),
        .src0_valid(src0_valid), .src1_valid(src1_valid),
        .src0_last(src0_last), .src1_last(src1_last),
        .src0_data(src0_data), .src1_data(src1_data),
        .src0_ready(src0_ready), .src1_ready(src1_ready),
        .f0_wr_en(f0_wr_en), .f1_wr_en(f1_wr_en), .din_f0(din_f0), .din_f1(din_f1),
        .f0_full(f0_full), .f1_full(f1_full),
        .atom_wr_en(atom_wr_en), .atom_dout(atom_dout),
        .global_en(global_en), .atom_rst_b(atom_rst_b),
        .busy(busy), .done(done), .err_order(err_order), .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int            rows0[$], rows1[$], emit_rows[$];
    logic [DW-1:0] src0_q[$], src1_q[$], fq0[$], fq1[$], wr0_log[$], wr1_log[$];
    int            s0_idx, s1_idx, k, n_sent_emit, n_done, n_flush, n_bp_viol, n_acc_viol;
    int            sent0_step, sent1_step, err_step, acc0_2_step;
    int            force1_lo, force1_hi, abort_at, restart_at, bubble_pct;
    bit            job_mode;
    logic          pend_v;
    logic [DW-1:0] pend_d;

    function automatic logic [DW-1:0] make_entry(input int row);
        logic [31:0] r;
        logic [7:0]  rr;
        r  = $urandom();
        rr = 8'(row);
        return {rr, r[22:0], 1'b1};
    endfunction

    // FIFO write log of a lane must equal its source entries followed by one sentinel
    function automatic bit lane_log_ok(input int lane);
        logic [DW-1:0] expq[$], got[$];
        expq = (lane == 0) ? src0_q : src1_q;
        got  = (lane == 0) ? wr0_log : wr1_log;
        expq.push_back(SENT);
        if (got.size() != expq.size()) return 1'b0;
        foreach (expq[i]) if (got[i] !== expq[i]) return 1'b0;
        return 1'b1;
    endfunction

    // emitted rows must be the sorted union of both lanes (or a prefix of it when aborted)
    function automatic bit merge_ok(input bit prefix_only);
        int expq[$];
        expq = rows0;
        foreach (rows1[i]) expq.push_back(rows1[i]);
        expq.sort();
        if (!prefix_only && emit_rows.size() != expq.size()) return 1'b0;
        if (emit_rows.size() > expq.size()) return 1'b0;
        foreach (emit_rows[i]) if (emit_rows[i] != expq[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit lanes_sorted();
        for (int i = 1; i < rows0.size(); i++) if (rows0[i] < rows0[i-1]) return 1'b0;
        for (int i = 1; i < rows1.size(); i++) if (rows1[i] < rows1[i-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic gen_lanes(input int n0, input int n1);
        rows0.delete();
        rows1.delete();
        for (int i = 0; i < n0; i++) rows0.push_back($urandom_range(200));
        for (int i = 0; i < n1; i++) rows1.push_back($urandom_range(200));
        rows0.sort();
        rows1.sort();
    endtask

    task automatic setup_job();
        src0_q.delete(); src1_q.delete(); wr0_log.delete(); wr1_log.delete(); emit_rows.delete();
        foreach (rows0[i]) src0_q.push_back(make_entry(rows0[i]));
        foreach (rows1[i]) src1_q.push_back(make_entry(rows1[i]));
        s0_idx = 0; s1_idx = 0; k = 0;
        n_sent_emit = 0; n_done = 0; n_flush = 0; n_bp_viol = 0; n_acc_viol = 0;
        sent0_step = -1; sent1_step = -1; err_step = -1; acc0_2_step = -1;
        lane0_empty = (rows0.size() == 0);
        lane1_empty = (rows1.size() == 0);
        job_mode = 1'b1;
    endtask

    // one clock: drive at negedge, observe #1 later, advance the environment model for the coming edge
    task automatic step();
        atom_wr_en = pend_v;
        atom_dout  = pend_v ? pend_d : DW'($urandom());
        src0_valid = (s0_idx < src0_q.size()) && ($urandom_range(99) >= bubble_pct);
        src1_valid = (s1_idx < src1_q.size()) && ($urandom_range(99) >= bubble_pct);
        src0_data  = src0_valid ? src0_q[s0_idx] : DW'($urandom());
        src1_data  = src1_valid ? src1_q[s1_idx] : DW'($urandom());
        src0_last  = src0_valid && (s0_idx == src0_q.size() - 1);
        src1_last  = src1_valid && (s1_idx == src1_q.size() - 1);
        f0_full    = (fq0.size() >= 4);
        f1_full    = (fq1.size() >= 4) || (k >= force1_lo && k < force1_hi);
        abort      = job_mode && (k == abort_at);
        start      = job_mode && (k == 0 || k == restart_at);
        #1;
        if ((f0_full && (src0_ready || f0_wr_en)) || (f1_full && (src1_ready || f1_wr_en))) n_bp_viol++;
        if (src0_valid && src0_ready) begin
            if (!(f0_wr_en && din_f0 === src0_data)) n_acc_viol++;
            s0_idx++;
            if (s0_idx == 2) acc0_2_step = k;
        end
        if (src1_valid && src1_ready) begin
            if (!(f1_wr_en && din_f1 === src1_data)) n_acc_viol++;
            s1_idx++;
        end
        if (f0_wr_en) begin
            wr0_log.push_back(din_f0);
            if (din_f0 === SENT && sent0_step < 0) sent0_step = k;
        end
        if (f1_wr_en) begin
            wr1_log.push_back(din_f1);
            if (din_f1 === SENT && sent1_step < 0) sent1_step = k;
        end
        if (atom_wr_en && global_en) begin
            if (atom_dout[0]) emit_rows.push_back(int'(atom_dout[31:24]));
            else n_sent_emit++;
        end
        if (done) n_done++;
        if (!atom_rst_b) n_flush++;
        if (err_order && err_step < 0) err_step = k;
        if (!atom_rst_b) begin
            fq0.delete(); fq1.delete(); pend_v = 1'b0;
        end else begin
            pend_v = 1'b0;
            if (global_en && fq0.size() > 0 && fq1.size() > 0) begin
                if (fq1[0][31:24] < fq0[0][31:24]) pend_d = fq1.pop_front();
                else pend_d = fq0.pop_front();
                pend_v = 1'b1;
            end
            if (f0_wr_en) fq0.push_back(din_f0);
            if (f1_wr_en) fq1.push_back(din_f1);
        end
        k++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_job();
        setup_job();
        while (n_done == 0 && k < 400) step();
        job_mode = 1'b0;
        step();
        step();
    endtask

    task automatic clear_knobs();
        force1_lo = -1; force1_hi = -1; abort_at = -1; restart_at = -1; bubble_pct = 0;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        rows0.delete(); rows1.delete();
        setup_job();
        job_mode = 1'b0;
        step();
        step();
        tests++; if (atom_rst_b !== 1'b0) begin fails++; $display("FAIL reset_atom_rst_b: got %b expected 0", atom_rst_b); end
        rst_b = 1'b1;
        #1;
        tests++; if ({global_en, busy, done, err_order} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {global_en, busy, done, err_order}); end
        tests++; if (out_count !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", out_count); end
        tests++; if (atom_rst_b !== 1'b1) begin fails++; $display("FAIL idle_atom_rst_b: got %b expected 1", atom_rst_b); end
    endtask

    task automatic test_basic();
        clear_knobs();
        rows0 = '{1, 4, 7};
        rows1 = '{2, 3};
        run_job();
        tests++; if (!merge_ok(0)) begin fails++; $display("FAIL basic_order: got %0d rows, expected 5 sorted", emit_rows.size()); end
        tests++; if (out_count !== 16'd5) begin fails++; $display("FAIL basic_count: got %0d expected 5", out_count); end
        tests++; if (n_flush != 1) begin fails++; $display("FAIL basic_flush: got %0d cycles expected 1", n_flush); end
        tests++; if (n_done != 1) begin fails++; $display("FAIL basic_done: got %0d cycles expected 1", n_done); end
        tests++; if (n_sent_emit != 1) begin fails++; $display("FAIL basic_sentinel: got %0d expected 1", n_sent_emit); end
        tests++; if (!lane_log_ok(0) || !lane_log_ok(1)) begin fails++; $display("FAIL basic_fifo_writes: got %0d/%0d writes expected 4/3", wr0_log.size(), wr1_log.size()); end
        tests++; if (busy !== 1'b0 || err_order !== 1'b0) begin fails++; $display("FAIL basic_idle: got busy=%b err=%b expected 0 0", busy, err_order); end
    endtask

    task automatic test_lane_empty();
        clear_knobs();
        rows0 = '{5};
        rows1.delete();
        run_job();
        tests++; if (sent1_step != 1) begin fails++; $display("FAIL empty_sentinel_step: got %0d expected 1", sent1_step); end
        tests++; if (!merge_ok(0) || out_count !== 16'd1) begin fails++; $display("FAIL empty_result: got count %0d expected 1", out_count); end
        tests++; if (!lane_log_ok(0) || !lane_log_ok(1)) begin fails++; $display("FAIL empty_fifo_writes: got %0d/%0d expected 2/1", wr0_log.size(), wr1_log.size()); end
    endtask

    task automatic test_both_empty();
        clear_knobs();
        rows0.delete();
        rows1.delete();
        run_job();
        tests++; if (sent0_step != 1 || sent1_step != 1) begin fails++; $display("FAIL both_empty_steps: got %0d/%0d expected 1/1", sent0_step, sent1_step); end
        tests++; if (out_count !== '0 || n_done != 1) begin fails++; $display("FAIL both_empty_result: got count %0d done %0d expected 0 1", out_count, n_done); end
    endtask

    task automatic test_backpressure();
        clear_knobs();
        gen_lanes(6, 6);
        force1_lo = 3; force1_hi = 13; bubble_pct = 20;
        run_job();
        tests++; if (n_bp_viol != 0) begin fails++; $display("FAIL bp_violation: got %0d expected 0", n_bp_viol); end
        tests++; if (n_acc_viol != 0) begin fails++; $display("FAIL bp_passthrough: got %0d expected 0", n_acc_viol); end
        tests++; if (!lane_log_ok(0) || !lane_log_ok(1)) begin fails++; $display("FAIL bp_fifo_writes: got %0d/%0d expected 7/7", wr0_log.size(), wr1_log.size()); end
        tests++; if (!merge_ok(0) || out_count !== 16'd12) begin fails++; $display("FAIL bp_result: got count %0d expected 12", out_count); end
    endtask

    task automatic test_abort();
        clear_knobs();
        gen_lanes(5, 5);
        abort_at = 3;
        run_job();
        tests++; if (n_flush != 1 || n_done != 1) begin fails++; $display("FAIL abort_pulses: got flush %0d done %0d expected 1 1", n_flush, n_done); end
        tests++; if (out_count !== CW'(emit_rows.size())) begin fails++; $display("FAIL abort_count: got %0d expected %0d", out_count, emit_rows.size()); end
        tests++; if (!merge_ok(1) || busy !== 1'b0) begin fails++; $display("FAIL abort_state: got busy %b, %0d rows expected idle prefix", busy, emit_rows.size()); end
        clear_knobs();
        gen_lanes(4, 3);
        run_job();
        tests++; if (!merge_ok(0) || out_count !== 16'd7) begin fails++; $display("FAIL after_abort_job: got count %0d expected 7", out_count); end
    endtask

    task automatic test_order_err();
        clear_knobs();
        rows0 = '{6, 2};
        rows1.delete();
        run_job();
        tests++; if (err_step != acc0_2_step + 1) begin fails++; $display("FAIL err_timing: got step %0d expected %0d", err_step, acc0_2_step + 1); end
        tests++; if (err_order !== 1'b1 || out_count !== 16'd2) begin fails++; $display("FAIL err_hold: got err %b count %0d expected 1 2", err_order, out_count); end
        clear_knobs();
        rows0 = '{3, 3, 9};
        rows1 = '{3};
        run_job();
        tests++; if (err_order !== 1'b0 || !merge_ok(0)) begin fails++; $display("FAIL err_clear_equal: got err %b expected 0", err_order); end
    endtask

    task automatic test_reset_mid_job();
        clear_knobs();
        rows0 = '{50, 10, 60, 70, 80, 90, 100, 110};
        rows1 = '{5, 15, 25, 35, 45, 55};
        setup_job();
        while (emit_rows.size() < 3 && k < 200) step();
        tests++; if (emit_rows.size() < 3 || err_order !== 1'b1) begin fails++; $display("FAIL midrst_setup: got %0d rows err %b expected 3 1", emit_rows.size(), err_order); end
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        job_mode = 1'b0;
        src0_valid = 1'b1;
        src1_valid = 1'b1;
        #1;
        tests++; if ({global_en, busy, done, err_order} !== 4'b0 || out_count !== '0) begin fails++; $display("FAIL midrst_flags: got %b count %0d expected 0000 0", {global_en, busy, done, err_order}, out_count); end
        tests++; if ({src0_ready, src1_ready, f0_wr_en, f1_wr_en} !== 4'b0 || din_f0 !== '0 || din_f1 !== '0) begin fails++; $display("FAIL midrst_lanes: got %b %h %h expected 0", {src0_ready, src1_ready, f0_wr_en, f1_wr_en}, din_f0, din_f1); end
        tests++; if (n_flush < 1) begin fails++; $display("FAIL midrst_atom_rst_b: got %0d low cycles expected >=1", n_flush); end
    endtask

    task automatic test_random();
        for (int j = 0; j < 12; j++) begin
            clear_knobs();
            gen_lanes($urandom_range(3, 9), $urandom_range(3, 9));
            bubble_pct = $urandom_range(0, 40);
            restart_at = $urandom_range(2, 5);
            if (j % 3 == 1) begin force1_lo = $urandom_range(2, 6); force1_hi = force1_lo + 10; end
            run_job();
            tests++;
            if (!merge_ok(0) || !lane_log_ok(0) || !lane_log_ok(1) || n_bp_viol != 0 || n_acc_viol != 0
                || out_count !== CW'(rows0.size() + rows1.size()) || n_done != 1 || n_flush != 1 || err_order !== !lanes_sorted()) begin
                fails++;
                $display("FAIL random_job%0d: got count %0d done %0d flush %0d bp %0d acc %0d, expected count %0d", j, out_count, n_done, n_flush, n_bp_viol, n_acc_viol, rows0.size() + rows1.size());
            end
        end
    endtask

    initial begin
        rst_b = 1'b0; start = 1'b0; abort = 1'b0; lane0_empty = 1'b0; lane1_empty = 1'b0;
        src0_valid = 1'b0; src1_valid = 1'b0; src0_last = 1'b0; src1_last = 1'b0;
        src0_data = '0; src1_data = '0; f0_full = 1'b0; f1_full = 1'b0;
        atom_wr_en = 1'b0; atom_dout = '0; pend_v = 1'b0; pend_d = '0; job_mode = 1'b0;
        clear_knobs();
        @(negedge clk);
        test_reset();
        test_basic();
        test_lane_empty();
        test_both_empty();
        test_backpressure();
        test_abort();
        test_order_err();
        test_reset_mid_job();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
